// File: rtl/nibble_serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl_pkg
// Description : Shared constants for the nibble-serial adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned c_NIBBLE = 4;

    localparam int unsigned c_ST_W    = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_RUN  = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_DONE = 2'd2;

endpackage : nibble_serial_adder_ctrl_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl_if
// Description : Start/operand/result bundle between requester and sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             i_START;
    logic             i_SUB;
    logic             i_CIN;
    logic [WIDTH-1:0] i_A;
    logic [WIDTH-1:0] i_B;
    logic [WIDTH-1:0] o_S;
    logic             o_C;
    logic             o_OVF;
    logic             o_BUSY;
    logic             o_DONE;

    modport master (
        output i_START, i_SUB, i_CIN, i_A, i_B,
        input  o_S, o_C, o_OVF, o_BUSY, o_DONE
    );

    modport slave (
        input  i_START, i_SUB, i_CIN, i_A, i_B,
        output o_S, o_C, o_OVF, o_BUSY, o_DONE
    );
endinterface : nibble_serial_adder_ctrl_if
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_adder
// Description : Combinational 4-bit ripple-carry adder with carry in/out.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  wire logic [c_NIBBLE-1:0] i_a,
    input  wire logic [c_NIBBLE-1:0] i_b,
    input  wire logic                i_cin,
    output logic      [c_NIBBLE-1:0] o_s,
    output logic                     o_cout
);
    logic [c_NIBBLE:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < c_NIBBLE; g++) begin : g_fa
        assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[c_NIBBLE];
endmodule : nibble_adder
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Streams WIDTH-bit add/sub one nibble per clock through one
//               shared 4-bit adder; start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic                   i_CLK,
    input  wire logic                   i_RST,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int NSTEPS = WIDTH / c_NIBBLE;
    localparam int STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [STEP_W-1:0] c_LAST = STEP_W'(NSTEPS - 1);

    logic [c_ST_W-1:0]   r_state;
    logic [c_ST_W-1:0]   w_next_state;
    logic [STEP_W-1:0]   r_step;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_sub;
    logic                r_carry;
    logic [WIDTH-1:0]    r_s;
    logic                r_c;
    logic                r_ovf;
    logic                w_busy;
    logic                w_done;
    logic                w_accept;
    logic                w_last;
    logic [c_NIBBLE-1:0] w_a_nib;
    logic [c_NIBBLE-1:0] w_b_nib;
    logic [c_NIBBLE-1:0] w_sum;
    logic                w_cout;

    assign w_accept = bus.i_START && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_last   = (r_state == c_ST_RUN) && (r_step == c_LAST);
    assign w_a_nib  = r_a[r_step*c_NIBBLE +: c_NIBBLE];
    assign w_b_nib  = r_b[r_step*c_NIBBLE +: c_NIBBLE];

    nibble_adder u_adder (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) r_state <= c_ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (bus.i_START) w_next_state = c_ST_RUN;
            c_ST_RUN:  if (w_last)      w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = bus.i_START ? c_ST_RUN : c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_ST_RUN:  w_busy = 1'b1;
            c_ST_DONE: w_done = 1'b1;
            default:   ;
        endcase
    end

    // Subtraction is A + ~B + ~borrow_in; the final carry is inverted back to a borrow.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_step  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_step  <= '0;
            r_a     <= bus.i_A;
            r_b     <= bus.i_SUB ? ~bus.i_B : bus.i_B;
            r_sub   <= bus.i_SUB;
            r_carry <= bus.i_SUB ? ~bus.i_CIN : bus.i_CIN;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == c_ST_RUN) begin
            r_s[r_step*c_NIBBLE +: c_NIBBLE] <= w_sum;
            r_carry <= w_cout;
            r_step  <= w_last ? '0 : r_step + 1'b1;
            if (w_last) begin
                r_c   <= w_cout ^ r_sub;
                r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[c_NIBBLE-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign bus.o_S    = r_s;
    assign bus.o_C    = r_c;
    assign bus.o_OVF  = r_ovf;
    assign bus.o_BUSY = w_busy;
    assign bus.o_DONE = w_done;
endmodule : nibble_serial_adder_ctrl
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder_ctrl
// Description : Self-checking bench; arithmetic reference model + directed
//               handshake scenarios with randomized operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;
    localparam int W     = 16;
    localparam int STEPS = W / 4;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   cyc;

    nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin,
                                  output logic [W-1:0] s, output logic c, output logic ovf);
        int r;
        r = sub ? (int'(a) - int'(b) - int'(cin)) : (int'(a) + int'(b) + int'(cin));
        s = r[W-1:0];
        c = sub ? (r < 0) : (r > 65535);
        ovf = sub ? ((a[W-1] != b[W-1]) && (s[W-1] != a[W-1]))
                  : ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sub, input logic cin);
        bus.i_A   = a;
        bus.i_B   = b;
        bus.i_SUB = sub;
        bus.i_CIN = cin;
    endtask

    // Called on the first falling edge after the accept edge.
    task automatic wait_done(input bit scramble, output int nb, output bit got);
        nb  = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_DONE) begin
                got = 1'b1;
                bus.i_START = 1'b0;
                break;
            end
            if (bus.o_BUSY) nb++;
            if (scramble) begin
                drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                bus.i_START = 1'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, input logic cin);
        logic [W-1:0] es;
        logic ec, eo;
        model(a, b, sub, cin, es, ec, eo);
        check({tag, ".S"},    32'(bus.o_S),   32'(es));
        check({tag, ".C"},    32'(bus.o_C),   32'(ec));
        check({tag, ".OVF"},  32'(bus.o_OVF), 32'(eo));
        check({tag, ".BUSY"}, 32'(bus.o_BUSY), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input bit scramble);
        int nb;
        bit got;
        @(negedge clk);
        drive_ops(a, b, sub, cin);
        bus.i_START = 1'b1;
        @(negedge clk);
        bus.i_START = 1'b0;
        wait_done(scramble, nb, got);
        check({tag, ".done_seen"}, 32'(got), 32'd1);
        check({tag, ".busy_cycles"}, 32'(nb), 32'(STEPS));
        check_result(tag, a, b, sub, cin);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.o_DONE), 32'd0);
        check({tag, ".S_hold"}, 32'(bus.o_S), 32'(bus.o_S === dut.r_s ? bus.o_S : 'x));
    endtask

    logic [W-1:0] da [6] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005};
    logic [W-1:0] db [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0007};
    logic         ds [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic         dc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int nb;
        bit got;
        int t1;
        int t2;
        logic [W-1:0] a1, b1, a2, b2;
        logic s1, c1, s2, c2;
        logic [W-1:0] es;
        logic ec, eo;
        bit saw_done;

        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        rst     = 1'b1;
        bus.i_START = 1'b0;
        drive_ops('0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outputs", {bus.o_S, bus.o_C, bus.o_OVF, bus.o_BUSY, bus.o_DONE}, 32'd0);
        end

        // Spec values cross-checked against the model so a broken model cannot hide.
        model(16'h00FF, 16'h0001, 1'b0, 1'b0, es, ec, eo);
        check("model_00FF", {es, ec, eo}, {16'h0100, 1'b0, 1'b0});
        model(16'h0005, 16'h0007, 1'b1, 1'b1, es, ec, eo);
        check("model_sub_cin", {es, ec, eo}, {16'hFFFD, 1'b1, 1'b0});

        for (int i = 0; i < 6; i++)
            run_op($sformatf("dir%0d", i), da[i], db[i], ds[i], dc[i], 1'b0);

        // Randomized operations; inputs and START toggle freely during RUN.
        for (int i = 0; i < 20; i++)
            run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom),
                   1'($urandom), 1'($urandom), 1'b1);

        // START held through DONE: second operation with no IDLE gap.
        a1 = W'($urandom); b1 = W'($urandom); s1 = 1'b0; c1 = 1'b1;
        a2 = W'($urandom); b2 = W'($urandom); s2 = 1'b1; c2 = 1'b0;
        @(negedge clk);
        drive_ops(a1, b1, s1, c1);
        bus.i_START = 1'b1;
        @(negedge clk);
        drive_ops(a2, b2, s2, c2);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_DONE) begin got = 1'b1; break; end
            @(negedge clk);
        end
        t1 = cyc;
        check("b2b.done1", 32'(got), 32'd1);
        check_result("b2b.op1", a1, b1, s1, c1);
        @(negedge clk);
        bus.i_START = 1'b0;
        check("b2b.no_gap_busy", 32'(bus.o_BUSY), 32'd1);
        wait_done(1'b0, nb, got);
        t2 = cyc;
        check("b2b.done2", 32'(got), 32'd1);
        check("b2b.spacing", 32'(t2 - t1), 32'd5);
        check_result("b2b.op2", a2, b2, s2, c2);

        // Reset during step 2 of a run.
        @(negedge clk);
        drive_ops(16'h1234, 16'h4321, 1'b0, 1'b0);
        bus.i_START = 1'b1;
        @(negedge clk);
        bus.i_START = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid_run", {bus.o_S, bus.o_C, bus.o_OVF, bus.o_BUSY, bus.o_DONE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.o_DONE || bus.o_BUSY) saw_done = 1'b1;
        end
        check("rst_no_done", 32'(saw_done), 32'd0);
        run_op("after_rst", 16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule : tb_nibble_serial_adder_ctrl
`default_nettype wire
